// File: rtl/uart_alu.sv
`default_nettype none
// ============================================================================
//  Module      : uart_alu
//  Description : UART-attached arithmetic block. Receives 8N1 command packets
//                (opcode, reserved, length, payload), performs echo, 32-bit
//                add or 32-bit multiply, and returns the result over 8N1 TX.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_alu #(
    parameter int ClksPerBit = 263
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rxd_i,
    output logic txd_o
);
    localparam int c_cnt_w = $clog2(ClksPerBit);
    localparam logic [c_cnt_w-1:0] c_bit_last = c_cnt_w'(ClksPerBit - 1);
    localparam logic [c_cnt_w-1:0] c_bit_half = c_cnt_w'(ClksPerBit / 2 - 1);
    localparam logic [7:0] c_op_echo = 8'hEC;
    localparam logic [7:0] c_op_add  = 8'hA0;
    localparam logic [7:0] c_op_mul  = 8'hA1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {P_OPCODE, P_RESERVED, P_LEN_LSB, P_LEN_MSB,
                              P_PAYLOAD, P_RESULT} parse_state_e;

    // ---------------- RX synchronizer ----------------
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rxd_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_e          rx_state_q, rx_state_d;
    logic [c_cnt_w-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;

    // Receiver: arm on falling edge, re-check start at half bit, sample centres
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + c_cnt_w'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == c_bit_half) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == c_bit_last) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == c_bit_last) begin
                // A low stop bit is a framing error: the byte is discarded
                rx_cnt_d   = '0;
                rx_state_d = RX_IDLE;
                if (rx_sync_q) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0] fifo_mem_q [16];
    logic [3:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [4:0] fifo_cnt_q, fifo_cnt_d;
    logic       fifo_push, fifo_pop, fifo_wr_en, fifo_empty;
    logic [7:0] fifo_wdata;

    // FIFO pointer bookkeeping; a push into a full FIFO is dropped
    always_comb begin
        fifo_empty = (fifo_cnt_q == 5'd0);
        fifo_wr_en = fifo_push && (fifo_cnt_q != 5'd16);
        fifo_wr_d  = fifo_wr_en ? fifo_wr_q + 4'd1 : fifo_wr_q;
        fifo_rd_d  = fifo_pop   ? fifo_rd_q + 4'd1 : fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q;
        if (fifo_wr_en && !fifo_pop)      fifo_cnt_d = fifo_cnt_q + 5'd1;
        else if (!fifo_wr_en && fifo_pop) fifo_cnt_d = fifo_cnt_q - 5'd1;
    end

    // FIFO pointer registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk_i) begin
        if (fifo_wr_en) fifo_mem_q[fifo_wr_q] <= fifo_wdata;
    end

    // ---------------- TX FSM ----------------
    tx_state_e          tx_state_q, tx_state_d;
    logic [c_cnt_w-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]         tx_bit_q, tx_bit_d;
    logic [7:0]         tx_shift_q, tx_shift_d;
    logic               txd_q, txd_d;

    // Transmitter: each bit held exactly ClksPerBit cycles; a queued byte
    // starts straight from the stop bit so result frames run back-to-back
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + c_cnt_w'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        fifo_pop   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                txd_d    = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shift_d = fifo_mem_q[fifo_rd_q];
                    tx_state_d = TX_START;
                    txd_d      = 1'b0;
                end
            end
            TX_START: if (tx_cnt_q == c_bit_last) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                txd_d      = tx_shift_q[0];
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_cnt_q == c_bit_last) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 3'd7) begin
                    txd_d      = 1'b1;
                    tx_state_d = TX_STOP;
                end else begin
                    tx_bit_d   = tx_bit_q + 3'd1;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end
            end
            TX_STOP: if (tx_cnt_q == c_bit_last) begin
                tx_cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shift_d = fifo_mem_q[fifo_rd_q];
                    tx_state_d = TX_START;
                    txd_d      = 1'b0;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // TX state register; line idles high from the first reset edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    assign txd_o = txd_q;

    // ---------------- Packet parser / ALU ----------------
    parse_state_e p_state_q, p_state_d;
    logic [7:0]   opcode_q, opcode_d;
    logic [15:0]  len_q, len_d;
    logic [1:0]   byte_idx_q, byte_idx_d;
    logic [31:0]  opnd_q, opnd_d;
    logic [31:0]  acc_q, acc_d;
    logic         first_q, first_d;
    logic [2:0]   res_cnt_q, res_cnt_d;
    logic [31:0]  operand;
    logic [15:0]  len_full;
    logic         is_arith;

    // Header decode, operand assembly (little endian), accumulate, result push
    always_comb begin
        p_state_d  = p_state_q;
        opcode_d   = opcode_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        first_d    = first_q;
        res_cnt_d  = res_cnt_q;
        fifo_push  = 1'b0;
        fifo_wdata = rx_data_q;
        operand    = {rx_data_q, opnd_q[31:8]};
        len_full   = {rx_data_q, len_q[7:0]};
        is_arith   = (opcode_q == c_op_add) || (opcode_q == c_op_mul);
        case (p_state_q)
            P_OPCODE: if (rx_valid_q) begin
                opcode_d   = rx_data_q;
                acc_d      = '0;
                first_d    = 1'b1;
                byte_idx_d = '0;
                res_cnt_d  = '0;
                p_state_d  = P_RESERVED;
            end
            P_RESERVED: if (rx_valid_q) p_state_d = P_LEN_LSB;
            P_LEN_LSB: if (rx_valid_q) begin
                len_d     = {8'h00, rx_data_q};
                p_state_d = P_LEN_MSB;
            end
            P_LEN_MSB: if (rx_valid_q) begin
                len_d     = len_full;
                p_state_d = (len_full == 16'd0) ? P_RESULT : P_PAYLOAD;
            end
            P_PAYLOAD: if (rx_valid_q) begin
                len_d      = len_q - 16'd1;
                opnd_d     = operand;
                byte_idx_d = byte_idx_q + 2'd1;
                if (opcode_q == c_op_echo) fifo_push = 1'b1;
                if (byte_idx_q == 2'd3) begin
                    if (opcode_q == c_op_add) acc_d = acc_q + operand;
                    if (opcode_q == c_op_mul) begin
                        acc_d   = first_q ? operand : acc_q * operand;
                        first_d = 1'b0;
                    end
                end
                if (len_q == 16'd1) p_state_d = P_RESULT;
            end
            P_RESULT: begin
                // Incoming bytes are ignored here until the response is out
                if (is_arith && res_cnt_q != 3'd4) begin
                    fifo_push  = 1'b1;
                    fifo_wdata = acc_q[{res_cnt_q[1:0], 3'b000} +: 8];
                    res_cnt_d  = res_cnt_q + 3'd1;
                end else if (fifo_empty && tx_state_q == TX_IDLE) begin
                    p_state_d = P_OPCODE;
                end
            end
            default: p_state_d = P_OPCODE;
        endcase
    end

    // Parser state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_state_q  <= P_OPCODE;
            opcode_q   <= '0;
            len_q      <= '0;
            byte_idx_q <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            first_q    <= 1'b1;
            res_cnt_q  <= '0;
        end else begin
            p_state_q  <= p_state_d;
            opcode_q   <= opcode_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            first_q    <= first_d;
            res_cnt_q  <= res_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_alu
//  Description : Scoreboard bench for uart_alu. Stimulus pushes expected TX
//                bytes into a queue; a line monitor decodes TX frames and
//                checks framing, bit width and data against the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_alu;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic txd;
    logic mon_en = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] pkt[$];

    uart_alu #(.ClksPerBit(CPB)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .rxd_i (rxd),
        .txd_o (txd)
    );

    always #5 clk = ~clk;

    // Serial driver: one 8N1 frame, stop bit value selectable
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    // Send every byte in pkt back-to-back, then clear it
    task automatic send_pkt();
        for (int i = 0; i < pkt.size(); i++) send_frame(pkt[i], 1'b1);
        pkt.delete();
    endtask

    task automatic expect4(input logic [31:0] v);
        for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
    endtask

    // Bounded wait for all expected responses to be consumed by the monitor
    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400 * CPB) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: outstanding=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Check the TX line stays high for a number of bit times
    task automatic check_quiet(input string name, input int bits);
        logic seen_low;
        seen_low = 1'b0;
        repeat (bits * CPB) begin
            @(negedge clk);
            if (txd !== 1'b1) seen_low = 1'b1;
        end
        checks++;
        if (seen_low) begin
            errors++;
            $display("FAIL %s: txd left idle, required steady 1", name);
        end
    endtask

    // TX monitor: decode frames, check framing/bit width, compare to scoreboard
    initial begin : monitor
        logic       prev;
        logic       aborted;
        logic       ok;
        logic       early [10];
        logic       late  [10];
        logic [7:0] got;
        logic [7:0] want;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev = 1'b1;
            end else begin
                if (prev && txd === 1'b0) begin
                    aborted = 1'b0;
                    for (int i = 0; i < 10; i++) begin
                        early[i] = 1'bx;
                        late[i]  = 1'bx;
                    end
                    for (int c = 1; c <= 10 * CPB - 2; c++) begin
                        @(negedge clk);
                        if (!mon_en) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c % CPB == 2)       early[c / CPB] = txd;
                        if (c % CPB == CPB - 2) late[c / CPB]  = txd;
                    end
                    if (!aborted) begin
                        ok = (early[0] === 1'b0) && (late[0] === 1'b0) &&
                             (early[9] === 1'b1) && (late[9] === 1'b1);
                        for (int i = 1; i < 9; i++) begin
                            if (early[i] !== late[i]) ok = 1'b0;
                            got[i-1] = late[i];
                        end
                        checks++;
                        if (!ok) begin
                            errors++;
                            $display("FAIL frame_shape: data=%h start=%b/%b stop=%b/%b, required start 0, stop 1, stable bits",
                                     got, early[0], late[0], early[9], late[9]);
                        end
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_frame: got=%h required=no frame", got);
                        end else begin
                            want = exp_q.pop_front();
                            if (got !== want) begin
                                errors++;
                                $display("FAIL tx_byte: got=%h required=%h", got, want);
                            end
                        end
                    end
                end
                prev = txd;
            end
        end
    end

    initial begin : stimulus
        // Reset: line must be idle high and stay so with no activity
        repeat (2) @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin
            errors++;
            $display("FAIL reset_txd: got=%b required=1", txd);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        check_quiet("reset_idle", 20);

        // Echo three bytes
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
        pkt = '{8'hEC, 8'h00, 8'h03, 8'h00, 8'h41, 8'h42, 8'h43};
        send_pkt();
        wait_drain("echo");

        // Add with carry wrap: 1 + 0xFFFFFFFF = 0
        expect4(32'h0000_0000);
        pkt = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_pkt();
        wait_drain("add_wrap");

        // Add: 5 + 7 = 12
        expect4(32'h0000_000C);
        pkt = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
                8'h07, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_drain("add");

        // Multiply: 3 * 5 * 0x10000000 = 0xF0000000
        expect4(32'hF000_0000);
        pkt = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
                8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
        send_pkt();
        wait_drain("mul");

        // Unknown opcode produces nothing; length-0 add right after gives 0
        pkt = '{8'h55, 8'h00, 8'h02, 8'h00, 8'hAA, 8'hBB};
        send_pkt();
        expect4(32'h0000_0000);
        pkt = '{8'hA0, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_drain("len0_add");

        // Framing error: bad-stop frame carrying 0xEC must not start a packet
        send_frame(8'hEC, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        exp_q.push_back(8'h77);
        pkt = '{8'hEC, 8'h00, 8'h01, 8'h00, 8'h77};
        send_pkt();
        wait_drain("framing_err");

        // Mid-packet reset after two of four echo payload bytes
        mon_en = 1'b0;
        pkt = '{8'hEC, 8'h00, 8'h04, 8'h00, 8'h11, 8'h22};
        send_pkt();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_txd: got=%b required=1", txd);
        end
        rst = 1'b0;
        check_quiet("mid_reset_quiet", 12);
        mon_en = 1'b1;
        exp_q.push_back(8'h5A);
        pkt = '{8'hEC, 8'h00, 8'h01, 8'h00, 8'h5A};
        send_pkt();
        wait_drain("post_reset_echo");

        check_quiet("final_idle", 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
